// File: rtl/instruction_fetch_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: default constants,
// fetch FSM states and the IF/ID pipeline register bundle.
package instruction_fetch_stage_pkg;

   localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      RUN,
      HALT
   } fetchState_t;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
   } ifId_t;

   // A fetch PC is usable only when word aligned and inside the 512-byte
   // instruction window that starts at the reset PC.
   function automatic logic pcInWindow(input logic [31:0] pcValue,
                                       input logic [31:0] windowBase);
      return (pcValue[1:0] == 2'b00) && (pcValue[31:9] == windowBase[31:9]);
   endfunction

endpackage

// File: rtl/instruction_fetch_stage_if_id_reg.sv
// IF/ID pipeline register. A bubble load takes priority over hold so a
// squash is never lost behind a hazard stall; reset also leaves a bubble.
module if_id_reg
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        hold,
   input  logic        bubble,
   input  logic [31:0] instIn,
   input  logic [31:0] pc4In,
   output ifId_t       ifId
);

   // Register update: reset, then bubble, then hold, otherwise load a real instruction.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ifId.inst  <= NOP_INST;
         ifId.pc4   <= 32'h0000_0000;
         ifId.valid <= 1'b0;
      end else if (bubble) begin
         ifId.inst  <= NOP_INST;
         ifId.pc4   <= pc4In;
         ifId.valid <= 1'b0;
      end else if (!hold) begin
         ifId.inst  <= instIn;
         ifId.pc4   <= pc4In;
         ifId.valid <= 1'b1;
      end
   end

endmodule

// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the combinational
// instruction memory, fills IF/ID and halts on an unusable fetch address.
module instruction_fetch_stage
   import instruction_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        stall,
   input  logic        flush,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [6:0]  inst_addr,
   input  logic [31:0] instruction,
   output logic [31:0] pc,
   output logic [31:0] if_id_inst,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid,
   output logic        addr_fault
);

   fetchState_t state;
   logic [31:0] pcPlus4;
   logic        pcOk;
   logic        ifIdHold;
   logic        ifIdBubble;
   ifId_t       ifIdBundle;

   assign pcPlus4   = pc + 32'd4;
   assign pcOk      = pcInWindow(pc, RESET_PC);
   assign inst_addr = pc[8:2];

   // IF/ID control: in RUN a squash beats a stall; in HALT the bubble
   // already loaded on the faulting edge is simply held.
   always_comb begin
      ifIdBubble = 1'b0;
      ifIdHold   = 1'b1;
      if (state == RUN) begin
         ifIdBubble = flush | redirect_valid | ~pcOk;
         ifIdHold   = stall;
      end
   end

   // Fetch FSM and PC: a bad PC halts with a sticky fault, a redirect beats
   // a stall, and otherwise the PC advances one word per cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= RUN;
         pc         <= RESET_PC;
         addr_fault <= 1'b0;
      end else if (state == RUN) begin
         if (!pcOk) begin
            state      <= HALT;
            addr_fault <= 1'b1;
         end else if (redirect_valid) begin
            pc <= redirect_pc;
         end else if (!stall) begin
            pc <= pcPlus4;
         end
      end
   end

   if_id_reg #(
      .NOP_INST (NOP_INST)
   ) ifIdReg (
      .clk    (clk),
      .rstn   (rstn),
      .hold   (ifIdHold),
      .bubble (ifIdBubble),
      .instIn (instruction),
      .pc4In  (pcPlus4),
      .ifId   (ifIdBundle)
   );

   assign if_id_inst  = ifIdBundle.inst;
   assign if_id_pc4   = ifIdBundle.pc4;
   assign if_id_valid = ifIdBundle.valid;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for the fetch stage: directed vectors push their
// hand-computed post-edge expectations, a monitor pops and compares.
module tb_instruction_fetch_stage;

   typedef struct {
      string       name;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc4;
      logic        valid;
      logic        fault;
   } expect_t;

   logic        clk;
   logic        rstn;
   logic        stall;
   logic        flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [6:0]  inst_addr;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] if_id_inst;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        addr_fault;

   expect_t scoreboard[$];
   int      checkCount = 0;
   int      passCount  = 0;

   instruction_fetch_stage dut (
      .clk            (clk),
      .rstn           (rstn),
      .stall          (stall),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_addr      (inst_addr),
      .instruction    (instruction),
      .pc             (pc),
      .if_id_inst     (if_id_inst),
      .if_id_pc4      (if_id_pc4),
      .if_id_valid    (if_id_valid),
      .addr_fault     (addr_fault)
   );

   // Instruction memory model: mem[k] = 0x1000_0000 + k.
   assign instruction = 32'h1000_0000 + {25'd0, inst_addr};

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkField(input string tag, input string field,
                             input logic [31:0] actual, input logic [31:0] required);
      checkCount++;
      if (actual === required) passCount++;
      else $display("[TB] FAIL %s.%s: got %h, required %h", tag, field, actual, required);
   endtask

   task automatic checkOutput(input expect_t e);
      logic [31:0] expPc;
      expPc = e.pc;
      checkField(e.name, "pc", pc, e.pc);
      checkField(e.name, "inst_addr", {25'd0, inst_addr}, {25'd0, expPc[8:2]});
      checkField(e.name, "if_id_inst", if_id_inst, e.inst);
      checkField(e.name, "if_id_pc4", if_id_pc4, e.pc4);
      checkField(e.name, "if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
      checkField(e.name, "addr_fault", {31'd0, addr_fault}, {31'd0, e.fault});
   endtask

   // Drive one cycle of inputs on the falling edge and queue what the
   // outputs must look like after the following rising edge.
   task automatic applyStimulus(input string name, input logic rstnV, input logic stallV,
                                input logic flushV, input logic rvV, input logic [31:0] rpcV,
                                input logic [31:0] expPc, input logic [31:0] expInst,
                                input logic [31:0] expPc4, input logic expValid,
                                input logic expFault);
      expect_t e;
      @(negedge clk);
      rstn           = rstnV;
      stall          = stallV;
      flush          = flushV;
      redirect_valid = rvV;
      redirect_pc    = rpcV;
      e.name  = name;
      e.pc    = expPc;
      e.inst  = expInst;
      e.pc4   = expPc4;
      e.valid = expValid;
      e.fault = expFault;
      scoreboard.push_back(e);
   endtask

   // Monitor: just after each rising edge, compare against the oldest expectation.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (scoreboard.size() > 0) begin
            e = scoreboard.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      rstn           = 1'b0;
      stall          = 1'b0;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;

      //            name          rstn stl fl rv rpc            pc             inst           pc4            v  f
      applyStimulus("reset0",     0,   0,  0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
      applyStimulus("reset1",     0,   0,  0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
      applyStimulus("run0",       1,   0,  0, 0, 32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
      applyStimulus("run1",       1,   0,  0, 0, 32'h0,         32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1, 0);
      applyStimulus("stall0",     1,   1,  0, 0, 32'h0,         32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1, 0);
      applyStimulus("stall1",     1,   1,  0, 0, 32'h0,         32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1, 0);
      applyStimulus("release",    1,   0,  0, 0, 32'h0,         32'h0000_000C, 32'h1000_0002, 32'h0000_000C, 1, 0);
      applyStimulus("redirStall", 1,   1,  0, 1, 32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 32'h0000_0010, 0, 0);
      applyStimulus("afterRedir", 1,   0,  0, 0, 32'h0,         32'h0000_0044, 32'h1000_0010, 32'h0000_0044, 1, 0);
      applyStimulus("flushStall", 1,   1,  1, 0, 32'h0,         32'h0000_0044, 32'h0000_0000, 32'h0000_0048, 0, 0);
      applyStimulus("afterFlush", 1,   0,  0, 0, 32'h0,         32'h0000_0048, 32'h1000_0011, 32'h0000_0048, 1, 0);
      applyStimulus("toEdge",     1,   0,  0, 1, 32'h0000_01F8, 32'h0000_01F8, 32'h0000_0000, 32'h0000_004C, 0, 0);
      applyStimulus("edge1F8",    1,   0,  0, 0, 32'h0,         32'h0000_01FC, 32'h1000_007E, 32'h0000_01FC, 1, 0);
      applyStimulus("edge1FC",    1,   0,  0, 0, 32'h0,         32'h0000_0200, 32'h1000_007F, 32'h0000_0200, 1, 0);
      applyStimulus("fault200",   1,   0,  0, 0, 32'h0,         32'h0000_0200, 32'h0000_0000, 32'h0000_0204, 0, 1);
      applyStimulus("haltIgnore", 1,   1,  1, 1, 32'h0000_0040, 32'h0000_0200, 32'h0000_0000, 32'h0000_0204, 0, 1);
      applyStimulus("haltIdle",   1,   0,  0, 0, 32'h0,         32'h0000_0200, 32'h0000_0000, 32'h0000_0204, 0, 1);
      applyStimulus("haltReset",  0,   0,  0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
      applyStimulus("rerun0",     1,   0,  0, 0, 32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
      applyStimulus("redir42",    1,   0,  0, 1, 32'h0000_0042, 32'h0000_0042, 32'h0000_0000, 32'h0000_0008, 0, 0);
      applyStimulus("fault42",    1,   0,  0, 0, 32'h0,         32'h0000_0042, 32'h0000_0000, 32'h0000_0046, 0, 1);
      applyStimulus("halt42",     1,   0,  0, 1, 32'h0000_0000, 32'h0000_0042, 32'h0000_0000, 32'h0000_0046, 0, 1);
      applyStimulus("resetMid",   0,   1,  0, 0, 32'h0,         32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 0, 0);
      applyStimulus("resume0",    1,   0,  0, 0, 32'h0,         32'h0000_0004, 32'h1000_0000, 32'h0000_0004, 1, 0);
      applyStimulus("resume1",    1,   0,  0, 0, 32'h0,         32'h0000_0008, 32'h1000_0001, 32'h0000_0008, 1, 0);

      for (int i = 0; i < 5 && scoreboard.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (scoreboard.size() != 0) begin
         checkCount++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", scoreboard.size());
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline; the initiator side of the instruction memory interface.
- Owns the PC, drives the 7-bit word address to the instruction memory, and consumes the combinational 32-bit instruction it returns.
- Registers fetched instruction plus PC+4 into the IF/ID pipeline register.
- Handles stall, flush, branch/jump redirect (no delay slot) and out-of-window/misaligned PC faults.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; must be 512-byte aligned.
- NOP_INST, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rstn  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- stall  in  1  hazard unit hold: PC and IF/ID keep their values.
- flush  in  1  squash IF/ID contents (bubble) at next edge.
- redirect_valid  in  1  taken branch/jump from ID/EX.
- redirect_pc  in  32  target of redirect.
- inst_addr  out  7  word address to instruction memory, equals pc[8:2].
- instruction  in  32  combinational read data from instruction memory.
- pc  out  32  current fetch PC.
- if_id_inst  out  32  registered instruction to decode.
- if_id_pc4  out  32  registered PC+4 of if_id_inst.
- if_id_valid  out  1  if_id_inst is a real, non-squashed instruction.
- addr_fault  out  1  sticky: fetch PC left window or was misaligned.

Behaviour:
- Reset (rstn=0 at an edge):
  - pc=RESET_PC, if_id_inst=NOP_INST, if_id_pc4=0, if_id_valid=0, addr_fault=0, state=RUN.
  - Reset overrides every other input, including mid-stall or in HALT.
- Latency:
  - Memory read is combinational; the instruction for pc is captured into IF/ID at the same edge.
  - Decode sees it one cycle after pc is presented.
- pc_ok = (pc[1:0]==0) and (pc[31:9]==RESET_PC[31:9]).
- FSM states: RUN, HALT.
- RUN, next-PC priority (highest first):
  1. !pc_ok: enter HALT, set addr_fault, pc holds, IF/ID gets bubble.
  2. redirect_valid: pc<=redirect_pc; IF/ID gets bubble (wrong-path squash). Redirect wins over stall.
  3. stall: pc holds.
  4. else: pc<=pc+4. 32-bit wrap is not special-cased; it is caught by pc_ok on the next cycle.
- RUN, IF/ID update priority (highest first):
  1. flush or redirect_valid or !pc_ok: if_id_inst=NOP_INST, if_id_valid=0, if_id_pc4=pc+4.
  2. stall: hold all IF/ID fields.
  3. else: if_id_inst=instruction, if_id_pc4=pc+4, if_id_valid=1.
- Simultaneous flush and stall: flush wins (bubble inserted); pc still holds.
- HALT:
  - pc frozen; IF/ID held at bubble; addr_fault stays 1.
  - stall, flush and redirect are ignored.
  - Only reset exits.
- Redirect to a misaligned or out-of-window target:
  - Target is loaded into pc.
  - Fault is raised the following cycle and nothing from that pc is marked valid.
- Boundary: pc=RESET_PC+0x1FC fetches normally; next pc RESET_PC+0x200 faults.
- inst_addr is always pc[8:2], including in HALT.

Decomposition:
- Shared pipeline package holds:
  - NOP_INST and default RESET_PC constants.
  - Fetch state enum {RUN, HALT}.
  - IF/ID bundle typedef {inst[31:0], pc4[31:0], valid}.
- Sub-module if_id_reg: IF/ID register with stall/bubble/load controls and reset-to-bubble.
- PC logic and FSM stay in the top block.

Test Plan:
- Reset then free run, mem[k]=32'h1000_0000+k: pc steps 0,4,8; if_id_inst follows one cycle later with pc4=4,8,12; valid=1 from the second cycle.
- stall=1 for 2 cycles at pc=8: pc stays 8, IF/ID holds mem[1]/pc4=8; after release mem[2] arrives with pc4=12.
- redirect_valid=1, redirect_pc=0x40, stall=1 in the same cycle: next pc=0x40, IF/ID bubble (valid=0, inst=0); next cycle IF/ID=mem[16].
- flush=1 with stall=1: IF/ID becomes bubble, pc unchanged.
- Run to pc=0x1FC, then 0x200: mem[127] captured valid; at 0x200 addr_fault=1, valid=0, pc frozen; stall, flush and redirect have no effect.
- Redirect to 0x42, then rstn=0 mid-HALT: fault the cycle after redirect; reset restores pc=0, addr_fault=0, normal fetch resumes.
